aes_dec_seq: RTL and testbench

//  Iterative AES-128 decryption core, one round per clock. Counterpart of the single-cycle

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_key_step.sv | 45 ++++
 rtl/aes_dec_seq.sv | 206 ++++++++++++++++++++
 tb/tb_aes_dec_seq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, forward/inverse S-box, round constants and FSM states.
// S-boxes are computed (inverse via x^254 plus affine map) rather than tabulated.
package aes_pkg;

  typedef enum logic [1:0] {StIdle, StKexp, StDec} state_e;

  // rcon[1..10]; index 0 and 11..15 are unused padding so a 4-bit round counter indexes safely.
  localparam logic [15:0][7:0] RCON = {40'h0, 8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08,
                                       8'h04, 8'h02, 8'h01, 8'h00};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gmul(gmul(a, a), a);
    x7   = gmul(gmul(x3, x3), a);
    x15  = gmul(gmul(x7, x7), a);
    x31  = gmul(gmul(x15, x15), a);
    x63  = gmul(gmul(x31, x31), a);
    x127 = gmul(gmul(x63, x63), a);
    return gmul(x127, x127);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] y;
    y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  // State byte (row r, column c) sits at bits [8*bidx+7 : 8*bidx].
  function automatic int bidx(input int r, input int c);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (dir=0: rk[i-1] -> rk[i]) or inverse (dir=1).
// The SubWord/RotWord S-boxes are shared between both directions.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  input  logic         dir,
  output logic [127:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] g_src, g_rot, g;

  assign w0 = key_in[31:0];
  assign w1 = key_in[63:32];
  assign w2 = key_in[95:64];
  assign w3 = key_in[127:96];

  // Inverse direction first recovers the previous w3 so the same g() function applies.
  assign g_src = dir ? (w3 ^ w2) : w3;
  assign g_rot = {g_src[7:0], g_src[31:8]};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      g[8*i +: 8] = sbox(g_rot[8*i +: 8]);
    end
    g[7:0] = g[7:0] ^ rcon;
  end

  always_comb begin
    if (dir) begin
      key_out[127:96] = w3 ^ w2;
      key_out[95:64]  = w2 ^ w1;
      key_out[63:32]  = w1 ^ w0;
      key_out[31:0]   = w0 ^ g;
    end else begin
      key_out[31:0]   = w0 ^ g;
      key_out[63:32]  = w1 ^ w0 ^ g;
      key_out[95:64]  = w2 ^ w1 ^ w0 ^ g;
      key_out[127:96] = w3 ^ w2 ^ w1 ^ w0 ^ g;
    end
  end

endmodule

// File: rtl/aes_dec_seq.sv
// Iterative AES-128 decryptor, one round per clock: forward key expansion, then inverse rounds.
// Define AES_DEC_KEYCACHE_EN to cache the last key's rk10 and skip expansion on a repeated key.
module aes_dec_seq
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10,
  parameter int unsigned KW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] g_input,
  input  logic [KW-1:0] e_input,
  output logic          busy,
  output logic          o_valid,
  output logic [KW-1:0] o
);

  if (NR != 10 || KW != 128) begin : g_cfg_check
    $error("aes_dec_seq supports only NR=10 and KW=128");
  end

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] o_q, o_d;
  logic         o_valid_q, o_valid_d;
  logic         hit;

  logic         ks_dir;
  logic [3:0]   rcon_idx;
  logic [127:0] ks_out;
  logic [127:0] round_out;

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    logic [127:0] m;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[8*bidx(r, c) +: 8] = inv_sbox(s[8*bidx(r, (c + 4 - r) % 4) +: 8]);
      end
    end
    t = t ^ rk;
    m = t;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[32*c +: 8];
        a1 = t[32*c+8 +: 8];
        a2 = t[32*c+16 +: 8];
        a3 = t[32*c+24 +: 8];
        m[32*c +: 8]    = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        m[32*c+8 +: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        m[32*c+16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        m[32*c+24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    return m;
  endfunction

  // Forward step uses rcon[rnd]; walking back from rk[rnd+1] to rk[rnd] uses rcon[rnd+1].
  assign ks_dir   = (state_q == StDec);
  assign rcon_idx = ks_dir ? (rnd_q + 4'd1) : rnd_q;

  aes_key_step u_key_step (
    .key_in  (key_q),
    .rcon    (RCON[rcon_idx]),
    .dir     (ks_dir),
    .key_out (ks_out)
  );

  assign round_out = inv_round(st_q, ks_out, rnd_q == 4'd0);

`ifdef AES_DEC_KEYCACHE_EN
  logic [127:0] cache_key_q, cache_key_d;
  logic [127:0] cache_rk_q, cache_rk_d;
  logic         cache_vld_q, cache_vld_d;
  logic         hit_q, hit_d;
  logic         cache_match;

  assign hit         = hit_q;
  assign cache_match = cache_vld_q && (g_input == cache_key_q);

  always_comb begin
    cache_key_d = cache_key_q;
    cache_rk_d  = cache_rk_q;
    cache_vld_d = cache_vld_q;
    hit_d       = hit_q;
    if (state_q == StIdle && start) begin
      hit_d = cache_match;
      // Cache key is claimed up front; valid returns only once its rk10 is stored.
      if (!cache_match) begin
        cache_key_d = g_input;
        cache_vld_d = 1'b0;
      end
    end else if (state_q == StKexp && !hit_q && rnd_q == 4'd10) begin
      cache_rk_d  = ks_out;
      cache_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_key_q <= '0;
      cache_rk_q  <= '0;
      cache_vld_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      cache_key_q <= cache_key_d;
      cache_rk_q  <= cache_rk_d;
      cache_vld_q <= cache_vld_d;
      hit_q       <= hit_d;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StKexp;
      StKexp:  if (hit || rnd_q == 4'd10) state_d = StDec;
      StDec:   if (rnd_q == 4'd0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != StIdle);
  end

  always_comb begin
    key_d     = key_q;
    st_d      = st_q;
    rnd_d     = rnd_q;
    o_d       = o_q;
    o_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          key_d = g_input;
          st_d  = e_input;
          rnd_d = 4'd1;
`ifdef AES_DEC_KEYCACHE_EN
          if (cache_match) key_d = cache_rk_q;
`endif
        end
      end
      StKexp: begin
        if (hit) begin
          st_d  = st_q ^ key_q;
          rnd_d = 4'd9;
        end else begin
          key_d = ks_out;
          rnd_d = rnd_q + 4'd1;
          if (rnd_q == 4'd10) begin
            st_d  = st_q ^ ks_out;
            rnd_d = 4'd9;
          end
        end
      end
      StDec: begin
        key_d = ks_out;
        st_d  = round_out;
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd0) begin
          o_d       = round_out;
          o_valid_d = 1'b1;
          rnd_d     = 4'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q     <= '0;
      st_q      <= '0;
      rnd_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
    end else begin
      key_q     <= key_d;
      st_q      <= st_d;
      rnd_q     <= rnd_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_aes_dec_seq.sv
// Scoreboard bench for aes_dec_seq: a byte-array AES-128 encryptor makes ciphertexts and the
// monitor checks every o_valid against the queued plaintext and expected latency.
module tb_aes_dec_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] g_input;
  logic [127:0] e_input;
  logic         busy;
  logic         o_valid;
  logic [127:0] o;

  aes_dec_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .g_input (g_input),
    .e_input (e_input),
    .busy    (busy),
    .o_valid (o_valid),
    .o       (o)
  );

  always #5 clk = ~clk;

`ifdef AES_DEC_KEYCACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  typedef struct {
    logic [127:0] pt;
    int           e0;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [7:0]   sbox_t[256];
  logic [127:0] mdl_key;
  bit           mdl_vld;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
    return y;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Classic generator walk: p runs over powers of 3, q over powers of 3^-1.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   w[176];
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   tmp[4];
    logic [7:0]   rc, x;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      w[i] = key[8*i +: 8];
      s[i] = pt[8*i +: 8];
    end
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        x      = tmp[0];
        tmp[0] = sbox_t[tmp[1]] ^ rc;
        tmp[1] = sbox_t[tmp[2]];
        tmp[2] = sbox_t[tmp[3]];
        tmp[3] = sbox_t[x];
        rc     = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rd < 10) begin
        for (int i = 0; i < 16; i++) t[i] = s[i];
        for (int c = 0; c < 4; c++)
          for (int i = 0; i < 4; i++)
            s[4*c+i] = xt(t[4*c+i]) ^ xt(t[4*c+(i+1)%4]) ^ t[4*c+(i+1)%4]
                       ^ t[4*c+(i+2)%4] ^ t[4*c+(i+3)%4];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rd+i];
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_o_valid: got o=%h, expected no output", o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("plaintext", o, e.pt);
        check("latency", 128'(cyc - e.e0), 128'(e.lat));
      end
    end
  end

  // Expected latency from the cache model; called at a negedge just before the accepting edge.
  function automatic int next_lat(input logic [127:0] key);
    int lat;
    lat = (CacheEn && mdl_vld && key == mdl_key) ? 11 : 20;
    if (lat == 20) begin
      mdl_key = key;
      mdl_vld = 1'b1;
    end
    return lat;
  endfunction

  task automatic push_exp(input logic [127:0] key, input logic [127:0] pt);
    exp_t e;
    e.pt  = pt;
    e.e0  = cyc + 1;
    e.lat = next_lat(key);
    sb.push_back(e);
  endtask

  // Call right after a negedge with the core idle; returns at the negedge after E0.
  task automatic issue(input logic [127:0] key, input logic [127:0] pt);
    g_input = key;
    e_input = aes_enc(key, pt);
    start   = 1'b1;
    push_exp(key, pt);
    @(negedge clk);
    start   = 1'b0;
    g_input = {$urandom, $urandom, $urandom, $urandom};
    e_input = {$urandom, $urandom, $urandom, $urandom};
    check("busy_after_start", busy, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got no o_valid within 40 cycles, expected %0d outputs", sb.size());
      sb.delete();
    end
    check("busy_idle", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    mdl_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  logic [127:0] k1, p1, rk, rp;

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    g_input = '0;
    e_input = '0;
    mdl_vld = 1'b0;
    build_sbox();
    k1 = bswap(128'h000102030405060708090a0b0c0d0e0f);
    p1 = bswap(128'h00112233445566778899aabbccddeeff);
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_o_valid", o_valid, 0);
    check("reset_o", o, 0);
    rst = 1'b1;
    @(negedge clk);

    // T1: FIPS-197 C.1 ciphertext driven as a constant, independent of the model.
    g_input = k1;
    e_input = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    start   = 1'b1;
    push_exp(k1, p1);
    @(negedge clk);
    start = 1'b0;
    check("t1_busy", busy, 1);
    drain();

    // T3: start pulses at E5 and E15 are ignored.
    do_reset();
    issue(k1, p1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_busy_e5", busy, 1);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_busy_e15", busy, 1);
    drain();
    repeat (25) @(negedge clk);

    // T4: reset at E12 aborts; a fresh op afterwards completes.
    do_reset();
    issue(k1, p1);
    repeat (11) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    mdl_vld = 1'b0;
    #1;
    check("t4_busy", busy, 0);
    check("t4_o_valid", o_valid, 0);
    check("t4_o", o, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    issue(k1, p1);
    drain();

    // T2: round trip with random keys and plaintexts.
    for (int n = 0; n < 1000; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      issue(rk, rp);
      drain();
    end

    // T5: start held high; each op accepted in the previous op's o_valid cycle.
    rk = {$urandom, $urandom, $urandom, $urandom};
    rp = {$urandom, $urandom, $urandom, $urandom};
    g_input = rk;
    e_input = aes_enc(rk, rp);
    start   = 1'b1;
    push_exp(rk, rp);
    for (int k = 0; k < 8; k++) begin
      repeat (20) @(negedge clk);
      check("t5_busy_e19", busy, 1);
      @(negedge clk);
      check("t5_busy_ovalid", busy, 0);
      check("t5_o_valid", o_valid, 1);
      if (k < 7) begin
        rk = {$urandom, $urandom, $urandom, $urandom};
        rp = {$urandom, $urandom, $urandom, $urandom};
        g_input = rk;
        e_input = aes_enc(rk, rp);
        push_exp(rk, rp);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);

    // T6: same key twice (cached build is faster), new key, then reset clears the cache.
    issue(k1, p1);
    drain();
    issue(k1, p1);
    drain();
    rk = {$urandom, $urandom, $urandom, $urandom};
    issue(rk, p1);
    drain();
    issue(rk, k1);
    drain();
    do_reset();
    issue(rk, p1);
    drain();

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
